// File: rtl/multi_timer_if.sv
// Handshake bundle for multi_timer: per-channel strobes, load values and status.
// The controller drives through master; the timer block connects as slave.
interface multi_timer_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4
);
    logic [NUM_CH-1:0]       start_timer;
    logic [NUM_CH-1:0]       cancel;
    logic                    pause;
    logic [NUM_CH-1:0]       reload_mode;
    logic [NUM_CH*WIDTH-1:0] value;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH*WIDTH-1:0] remaining;

    modport master (
        output start_timer, cancel, pause, reload_mode, value,
        input  busy, expired, remaining
    );

    modport slave (
        input  start_timer, cancel, pause, reload_mode, value,
        output busy, expired, remaining
    );
endinterface

// File: rtl/multi_timer.sv
// NUM_CH independent down-counting timers with one-shot/auto-reload modes,
// a shared pause and registered busy/expired/remaining status.
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4
) (
    input  logic         clk_1hz,
    input  logic         rst,
    multi_timer_if.slave tif
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q   [NUM_CH];
    logic [WIDTH-1:0]  cnt_d   [NUM_CH];
    logic [WIDTH-1:0]  rld_q   [NUM_CH];
    logic [WIDTH-1:0]  rld_d   [NUM_CH];
    logic [NUM_CH-1:0] exp_q;
    logic [NUM_CH-1:0] exp_d;

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                rld_q[i]   <= '0;
            end
            exp_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                rld_q[i]   <= rld_d[i];
            end
            exp_q <= exp_d;
        end
    end

    // Per channel: cancel > start > pause > count; expiry happens at count 0.
    always_comb begin
        exp_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rld_d[i]   = rld_q[i];
            if (tif.cancel[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (tif.start_timer[i]) begin
                state_d[i] = RUN;
                cnt_d[i]   = tif.value[i*WIDTH +: WIDTH];
                rld_d[i]   = tif.value[i*WIDTH +: WIDTH];
            end else if (state_q[i] == RUN && !tif.pause) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - ONE;
                end else begin
                    exp_d[i] = 1'b1;
                    if (tif.reload_mode[i]) begin
                        cnt_d[i] = rld_q[i];
                    end else begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        tif.busy      = '0;
        tif.remaining = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tif.busy[i]                    = (state_q[i] == RUN);
            tif.remaining[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign tif.expired = exp_q;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: directed vectors push expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_multi_timer;
    localparam int NCH = 4;
    localparam int W   = 4;

    typedef struct {
        logic [3:0]  busy;
        logic [3:0]  expd;
        logic [15:0] rem;
        string       name;
    } exp_t;

    logic   clk_1hz = 1'b0;
    logic   rst;
    exp_t   sbq[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk_1hz = ~clk_1hz;

    multi_timer_if #(.NUM_CH(NCH), .WIDTH(W)) tif ();

    multi_timer #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .tif     (tif)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(posedge clk_1hz) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, ".busy"}, {12'h0, tif.busy}, {12'h0, e.busy});
            chk({e.name, ".expired"}, {12'h0, tif.expired}, {12'h0, e.expd});
            chk({e.name, ".remaining"}, tif.remaining, e.rem);
        end
    end

    // Drive one cycle of inputs and queue what must appear after the edge.
    task automatic step(input logic [3:0] st, input logic [3:0] cn,
                        input logic ps, input logic [3:0] md,
                        input logic [15:0] val, input logic [3:0] eb,
                        input logic [3:0] ee, input logic [15:0] er,
                        input string nm);
        exp_t e;
        @(negedge clk_1hz);
        tif.start_timer = st;
        tif.cancel      = cn;
        tif.pause       = ps;
        tif.reload_mode = md;
        tif.value       = val;
        e.busy = eb;
        e.expd = ee;
        e.rem  = er;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [3:0] md, input logic [3:0] eb,
                        input logic [3:0] ee, input logic [15:0] er,
                        input string nm);
        step(4'h0, 4'h0, 1'b0, md, 16'hFFFF, eb, ee, er, nm);
    endtask

    initial begin
        rst             = 1'b1;
        tif.start_timer = '0;
        tif.cancel      = '0;
        tif.pause       = 1'b0;
        tif.reload_mode = '0;
        tif.value       = '0;
        repeat (2) @(negedge clk_1hz);
        chk("por.busy", {12'h0, tif.busy}, 16'h0);
        chk("por.remaining", tif.remaining, 16'h0);
        rst = 1'b0;

        // asynchronous reset mid-count
        step(4'h1, 4'h0, 1'b0, 4'h0, 16'h0005, 4'h1, 4'h0, 16'h0005, "rst_ld");
        idle(4'h0, 4'h1, 4'h0, 16'h0004, "rst_cnt");
        @(negedge clk_1hz);
        tif.start_timer = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_async.busy", {12'h0, tif.busy}, 16'h0);
        chk("rst_async.expired", {12'h0, tif.expired}, 16'h0);
        chk("rst_async.remaining", tif.remaining, 16'h0);
        repeat (2) @(negedge clk_1hz);
        rst = 1'b0;
        for (int k = 0; k < 6; k++)
            idle(4'h0, 4'h0, 4'h0, 16'h0000, "rst_after");

        // ch0 one-shot, value 3; value changes while running are ignored
        step(4'h1, 4'h0, 1'b0, 4'h0, 16'h0003, 4'h1, 4'h0, 16'h0003, "os_e0");
        idle(4'h0, 4'h1, 4'h0, 16'h0002, "os_e1");
        idle(4'h0, 4'h1, 4'h0, 16'h0001, "os_e2");
        idle(4'h0, 4'h1, 4'h0, 16'h0000, "os_e3");
        idle(4'h0, 4'h0, 4'h1, 16'h0000, "os_e4");
        idle(4'h0, 4'h0, 4'h0, 16'h0000, "os_e5");

        // ch1 auto-reload, value 2; mode cleared before the third expiry
        step(4'h2, 4'h0, 1'b0, 4'h2, 16'h0020, 4'h2, 4'h0, 16'h0020, "ar_e0");
        idle(4'h2, 4'h2, 4'h0, 16'h0010, "ar_e1");
        idle(4'h2, 4'h2, 4'h0, 16'h0000, "ar_e2");
        idle(4'h2, 4'h2, 4'h2, 16'h0020, "ar_e3");
        idle(4'h2, 4'h2, 4'h0, 16'h0010, "ar_e4");
        idle(4'h2, 4'h2, 4'h0, 16'h0000, "ar_e5");
        idle(4'h2, 4'h2, 4'h2, 16'h0020, "ar_e6");
        idle(4'h2, 4'h2, 4'h0, 16'h0010, "ar_e7");
        idle(4'h2, 4'h2, 4'h0, 16'h0000, "ar_e8");
        idle(4'h0, 4'h0, 4'h2, 16'h0000, "ar_e9");
        idle(4'h0, 4'h0, 4'h0, 16'h0000, "ar_e10");

        // ch2 value 4, paused for three edges after reaching 2
        step(4'h4, 4'h0, 1'b0, 4'h0, 16'h0400, 4'h4, 4'h0, 16'h0400, "ps_e0");
        idle(4'h0, 4'h4, 4'h0, 16'h0300, "ps_e1");
        idle(4'h0, 4'h4, 4'h0, 16'h0200, "ps_e2");
        for (int k = 0; k < 3; k++)
            step(4'h0, 4'h0, 1'b1, 4'h0, 16'h0, 4'h4, 4'h0, 16'h0200, "ps_hold");
        idle(4'h0, 4'h4, 4'h0, 16'h0100, "ps_e6");
        idle(4'h0, 4'h4, 4'h0, 16'h0000, "ps_e7");
        idle(4'h0, 4'h0, 4'h4, 16'h0000, "ps_e8");
        idle(4'h0, 4'h0, 4'h0, 16'h0000, "ps_e9");

        // expiry falling due under pause is deferred
        step(4'h4, 4'h0, 1'b0, 4'h0, 16'h0000, 4'h4, 4'h0, 16'h0000, "df_ld");
        step(4'h0, 4'h0, 1'b1, 4'h0, 16'h0, 4'h4, 4'h0, 16'h0000, "df_hold");
        idle(4'h0, 4'h0, 4'h4, 16'h0000, "df_exp");

        // cancel beats start; cancel while paused
        step(4'h8, 4'h8, 1'b0, 4'h0, 16'hF000, 4'h0, 4'h0, 16'h0000, "cf_both");
        idle(4'h0, 4'h0, 4'h0, 16'h0000, "cf_after");
        step(4'h8, 4'h0, 1'b0, 4'h0, 16'h5000, 4'h8, 4'h0, 16'h5000, "cf_ld");
        step(4'h0, 4'h8, 1'b1, 4'h0, 16'h0, 4'h0, 4'h0, 16'h0000, "cf_pcan");

        // retrigger ch0 at remaining 1 with 6
        step(4'h1, 4'h0, 1'b0, 4'h0, 16'h0002, 4'h1, 4'h0, 16'h0002, "rt_ld");
        idle(4'h0, 4'h1, 4'h0, 16'h0001, "rt_r1");
        step(4'h1, 4'h0, 1'b0, 4'h0, 16'h0006, 4'h1, 4'h0, 16'h0006, "rt_re");
        for (int k = 5; k >= 0; k--)
            idle(4'h0, 4'h1, 4'h0, 16'(k), "rt_cnt");
        idle(4'h0, 4'h0, 4'h1, 16'h0000, "rt_exp");

        // N=0 auto-reload pulses every cycle until cancelled
        step(4'h1, 4'h0, 1'b0, 4'h1, 16'h0000, 4'h1, 4'h0, 16'h0000, "z_ld");
        idle(4'h1, 4'h1, 4'h1, 16'h0000, "z_p1");
        idle(4'h1, 4'h1, 4'h1, 16'h0000, "z_p2");
        step(4'h0, 4'h1, 1'b0, 4'h1, 16'h0, 4'h0, 4'h0, 16'h0000, "z_can");

        // ch0 and ch1 expire together
        step(4'h3, 4'h0, 1'b0, 4'h0, 16'h0011, 4'h3, 4'h0, 16'h0011, "sim_ld");
        idle(4'h0, 4'h3, 4'h0, 16'h0000, "sim_z");
        idle(4'h0, 4'h0, 4'h3, 16'h0000, "sim_exp");
        idle(4'h0, 4'h0, 4'h0, 16'h0000, "sim_end");

        for (int k = 0; k < 5 && sbq.size() > 0; k++)
            @(posedge clk_1hz);
        #3;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
